// File: rtl/armleocpu_ptw_arbiter.sv
// Two-requester arbiter in front of a single page table walker.
// Requester 0 is instruction fetch; requester 1 is load/store.
module armleocpu_ptw_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        async_rst_n,

  input  logic [1:0]  req_resolve_request,
  output logic [1:0]  req_resolve_ack,
  input  logic [19:0] req_virtual_address_0,
  input  logic [19:0] req_virtual_address_1,
  output logic [1:0]  req_resolve_done,
  output logic        req_resolve_pagefault,
  output logic        req_resolve_accessfault,
  output logic [7:0]  req_resolve_access_bits,
  output logic [21:0] req_resolve_physical_address,

  input  logic        flush,

  output logic        ptw_resolve_request,
  input  logic        ptw_resolve_ack,
  output logic [19:0] ptw_virtual_address,
  input  logic        ptw_resolve_done,
  input  logic        ptw_resolve_pagefault,
  input  logic        ptw_resolve_accessfault,
  input  logic [7:0]  ptw_resolve_access_bits,
  input  logic [21:0] ptw_resolve_physical_address
);

  // Handshakes: a requester holds req_resolve_request high until it sees its
  // one-cycle req_resolve_ack; ptw_resolve_request/ptw_virtual_address stay
  // stable until ptw_resolve_ack; req_resolve_done is a one-cycle pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_grant, last_grant_nxt;
  logic [19:0] vpn, vpn_nxt;
  logic        drop, drop_nxt;
  logic        winner;

  always_comb begin
    if (&req_resolve_request)
      winner = FIXED_PRIORITY ? 1'b1 : !last_grant;
    else
      winner = req_resolve_request[1];
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      vpn        <= 20'd0;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      vpn        <= vpn_nxt;
      drop       <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    owner_nxt           = owner;
    last_grant_nxt      = last_grant;
    vpn_nxt             = vpn;
    drop_nxt            = drop;
    req_resolve_ack     = 2'b00;
    req_resolve_done    = 2'b00;
    ptw_resolve_request = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_resolve_request) && !flush) begin
          req_resolve_ack[winner] = 1'b1;
          owner_nxt = winner;
          vpn_nxt   = winner ? req_virtual_address_1 : req_virtual_address_0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ptw_resolve_request = 1'b1;
        if (ptw_resolve_ack) begin
          state_nxt = WAIT;
          drop_nxt  = flush;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (ptw_resolve_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
          drop_nxt       = 1'b0;
          // A flushed walk still runs to completion; only its result is hidden.
          if (!drop && !flush)
            req_resolve_done[owner] = 1'b1;
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ptw_virtual_address          = vpn;
  assign req_resolve_pagefault        = ptw_resolve_pagefault;
  assign req_resolve_accessfault      = ptw_resolve_accessfault;
  assign req_resolve_access_bits      = ptw_resolve_access_bits;
  assign req_resolve_physical_address = ptw_resolve_physical_address;

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// Directed bench for armleocpu_ptw_arbiter: round-robin instance with a
// scoreboard on ack/done, plus a fixed-priority instance checked inline.
module tb_armleocpu_ptw_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [1:0]  req = 2'b00;
  logic [19:0] va0 = 20'd0, va1 = 20'd0;
  logic        flush = 1'b0;
  logic        p_ack = 1'b0, p_done = 1'b0, p_pf = 1'b0, p_af = 1'b0;
  logic [7:0]  p_bits = 8'd0;
  logic [21:0] p_pa = 22'd0;
  logic [1:0]  ack, done;
  logic        r_pf, r_af, p_req;
  logic [7:0]  r_bits;
  logic [21:0] r_pa;
  logic [19:0] p_va;

  armleocpu_ptw_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .async_rst_n(rst_n),
    .req_resolve_request(req), .req_resolve_ack(ack),
    .req_virtual_address_0(va0), .req_virtual_address_1(va1),
    .req_resolve_done(done), .req_resolve_pagefault(r_pf),
    .req_resolve_accessfault(r_af), .req_resolve_access_bits(r_bits),
    .req_resolve_physical_address(r_pa), .flush(flush),
    .ptw_resolve_request(p_req), .ptw_resolve_ack(p_ack),
    .ptw_virtual_address(p_va), .ptw_resolve_done(p_done),
    .ptw_resolve_pagefault(p_pf), .ptw_resolve_accessfault(p_af),
    .ptw_resolve_access_bits(p_bits), .ptw_resolve_physical_address(p_pa)
  );

  // Fixed-priority instance
  logic [1:0]  f_req = 2'b00;
  logic        f_pack = 1'b0, f_pdone = 1'b0;
  logic [1:0]  f_ack, f_done;
  logic        f_rpf, f_raf, f_preq;
  logic [7:0]  f_rbits;
  logic [21:0] f_rpa;
  logic [19:0] f_pva;

  armleocpu_ptw_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .async_rst_n(rst_n),
    .req_resolve_request(f_req), .req_resolve_ack(f_ack),
    .req_virtual_address_0(20'h00AAA), .req_virtual_address_1(20'h00BBB),
    .req_resolve_done(f_done), .req_resolve_pagefault(f_rpf),
    .req_resolve_accessfault(f_raf), .req_resolve_access_bits(f_rbits),
    .req_resolve_physical_address(f_rpa), .flush(1'b0),
    .ptw_resolve_request(f_preq), .ptw_resolve_ack(f_pack),
    .ptw_virtual_address(f_pva), .ptw_resolve_done(f_pdone),
    .ptw_resolve_pagefault(1'b0), .ptw_resolve_accessfault(1'b0),
    .ptw_resolve_access_bits(8'h00), .ptw_resolve_physical_address(22'h0)
  );

  int checks = 0;
  int passed = 0;
  logic [1:0]  ack_q[$];
  logic [33:0] done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack/done the DUT presents must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack !== 2'b00) begin
        if (ack_q.size() == 0) chk("ack_unexpected", {62'd0, ack}, 64'd0);
        else chk("ack", {62'd0, ack}, {62'd0, ack_q.pop_front()});
      end
      if (done !== 2'b00) begin
        if (done_q.size() == 0) chk("done_unexpected", {62'd0, done}, 64'd0);
        else chk("done", {30'd0, done, r_pf, r_af, r_bits, r_pa}, {30'd0, done_q.pop_front()});
      end
    end
  end

  // Raise a request in IDLE, expect the grant this cycle, then drop it.
  task automatic issue_req(input logic [1:0] r, input logic [1:0] exp_grant);
    req = r;
    ack_q.push_back(exp_grant);
    tick;
    req = 2'b00;
  endtask

  // Serve a walk from ISSUE: busy cycles, ack, lat WAIT cycles, then done.
  task automatic serve(input int busy, input logic [19:0] exp_va, input logic [1:0] owner_oh,
                       input logic pf, input logic [7:0] bits, input logic [21:0] pa, input int lat);
    repeat (busy) begin
      p_ack = 1'b0;
      @(negedge clk);
      chk("ptw_req_busy", {63'd0, p_req}, 64'd1);
      chk("ptw_va_busy", {44'd0, p_va}, {44'd0, exp_va});
      tick;
    end
    p_ack = 1'b1;
    @(negedge clk);
    chk("ptw_req", {63'd0, p_req}, 64'd1);
    chk("ptw_va", {44'd0, p_va}, {44'd0, exp_va});
    tick;
    p_ack = 1'b0;
    repeat (lat) tick;
    p_done = 1'b1; p_pf = pf; p_bits = bits; p_pa = pa;
    if (owner_oh != 2'b00) done_q.push_back({owner_oh, pf, 1'b0, bits, pa});
    tick;
    p_done = 1'b0; p_pf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va0 = 20'h12345;
    va1 = 20'hFEDCB;
    #12;
    chk("rst_ack", {62'd0, ack}, 64'd0);
    chk("rst_done", {62'd0, done}, 64'd0);
    chk("rst_ptw_req", {63'd0, p_req}, 64'd0);
    chk("rst_ptw_va", {44'd0, p_va}, 64'd0);
    rst_n = 1'b1;
    tick;

    // First tie goes to requester 0, next tie to requester 1
    issue_req(2'b11, 2'b01);
    serve(0, 20'h12345, 2'b01, 1'b0, 8'h11, 22'h00111, 1);
    issue_req(2'b11, 2'b10);
    serve(0, 20'hFEDCB, 2'b10, 1'b0, 8'h22, 22'h00222, 1);

    // Single walk with a changed VA; PTW busy for 5 cycles
    va0 = 20'h0A5A5;
    issue_req(2'b01, 2'b01);
    va0 = 20'h12345;
    serve(5, 20'h0A5A5, 2'b01, 1'b0, 8'h5A, 22'h0ABCD, 2);

    // Flush in IDLE blocks the grant for that cycle
    req = 2'b01; flush = 1'b1;
    tick;
    flush = 1'b0;
    issue_req(2'b01, 2'b01);
    serve(0, 20'h12345, 2'b01, 1'b1, 8'hC3, 22'h3FFFF, 0);

    // Flush in WAIT hides the done; next request granted right after
    issue_req(2'b01, 2'b01);
    p_ack = 1'b1;
    tick;
    p_ack = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
    p_done = 1'b1; p_pf = 1'b1; p_pa = 22'h0DEAD;
    tick;
    p_done = 1'b0; p_pf = 1'b0;
    issue_req(2'b10, 2'b10);
    serve(0, 20'hFEDCB, 2'b10, 1'b0, 8'h77, 22'h15555, 1);

    // Flush in ISSUE without ack: request withdrawn, back to IDLE
    issue_req(2'b01, 2'b01);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_issue_req_now", {63'd0, p_req}, 64'd1);
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_issue_req_next", {63'd0, p_req}, 64'd0);
    tick;

    // Reset during WAIT
    issue_req(2'b01, 2'b01);
    p_ack = 1'b1;
    tick;
    p_ack = 1'b0;
    p_done = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_done", {62'd0, done}, 64'd0);
    chk("rstw_ack", {62'd0, ack}, 64'd0);
    chk("rstw_ptw_req", {63'd0, p_req}, 64'd0);
    chk("rstw_ptw_va", {44'd0, p_va}, 64'd0);
    p_done = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    issue_req(2'b10, 2'b10);
    serve(0, 20'hFEDCB, 2'b10, 1'b0, 8'h3C, 22'h2AAAA, 1);

    // Fixed priority: requester 1 wins ties every time
    f_req = 2'b11;
    @(negedge clk);
    chk("fp_ack1", {62'd0, f_ack}, 64'd2);
    tick;
    f_pack = 1'b1;
    @(negedge clk);
    chk("fp_ptw_va", {44'd0, f_pva}, 64'h00BBB);
    tick;
    f_pack = 1'b0;
    f_pdone = 1'b1;
    @(negedge clk);
    chk("fp_done", {62'd0, f_done}, 64'd2);
    chk("fp_no_ack_on_done", {62'd0, f_ack}, 64'd0);
    tick;
    f_pdone = 1'b0;
    @(negedge clk);
    chk("fp_ack2", {62'd0, f_ack}, 64'd2);
    tick;
    f_req = 2'b00;
    tick;

    repeat (3) tick;
    chk("ack_q_empty", ack_q.size(), 64'd0);
    chk("done_q_empty", done_q.size(), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
